// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot/run/halt control, redirect priority with
// alignment checking, exception vectoring and an accepted-fetch counter.
module pc_sequencer #(
  parameter int unsigned          WIDTH        = 32,
  parameter int unsigned          STEP         = 4,
  parameter logic [WIDTH-1:0]     RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0]     EXC_VECTOR   = WIDTH'('h180)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             jr,
  input  logic [WIDTH-1:0] reg_target,
  input  logic             exception,
  input  logic             halt,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             pc_valid,
  output logic             misaligned,
  output logic [1:0]       state,
  output logic [WIDTH-1:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    UNUSED  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] STEP_MASK = STEP_W - WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             mis_q, mis_d;
  logic             redirect;
  logic [WIDTH-1:0] target;

  function automatic logic is_aligned(input logic [WIDTH-1:0] addr);
    return (addr & STEP_MASK) == '0;
  endfunction

  assign pc_plus_step = pc_q + STEP_W;

  // Redirect priority: jr > jump > branch > sequential.
  always_comb begin
    redirect = 1'b1;
    target   = reg_target;
    if (jr)                target = reg_target;
    else if (jump)         target = jump_target;
    else if (branch_taken) target = branch_target;
    else begin
      redirect = 1'b0;
      target   = pc_plus_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = 1'b0;
    cnt_d   = cnt_q;
    if ((state_q == RUN) && !stall) cnt_d = cnt_q + WIDTH'(1);
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (exception) begin
          pc_d = EXC_VECTOR;
        end else if (halt && !stall) begin
          state_d = HALTED;
        end else if (!stall) begin
          // A misaligned redirect is replaced by the exception vector.
          if (redirect && !is_aligned(target)) begin
            pc_d  = EXC_VECTOR;
            mis_d = 1'b1;
          end else begin
            pc_d = target;
          end
        end
      end
      HALTED: begin
        if (exception) begin
          pc_d    = EXC_VECTOR;
          state_d = RUN;
        end else if (resume) begin
          pc_d    = pc_plus_step;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_valid    = (state_q == RUN);
    pc          = pc_q;
    state       = state_q;
    misaligned  = mis_q;
    fetch_count = cnt_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven scoreboard bench for pc_sequencer (WIDTH=32, STEP=4).
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall, branch_taken, jump, jr, exception, halt, resume;
  logic [31:0] branch_target, jump_target, reg_target;
  logic [31:0] pc, pc_plus_step, fetch_count;
  logic        pc_valid, misaligned;
  logic [1:0]  state;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .jr(jr), .reg_target(reg_target),
    .exception(exception), .halt(halt), .resume(resume),
    .pc(pc), .pc_plus_step(pc_plus_step), .pc_valid(pc_valid),
    .misaligned(misaligned), .state(state), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall, exc, halt, resume, jr, jmp, br;
    logic [31:0] rt, jt, bt;
    logic [31:0] e_pc;
    logic [1:0]  e_st;
    logic        e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [1:0]  st;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input string nm, input logic s, input logic e,
                              input logic h, input logic r,
                              input logic j_r, input logic [31:0] rt_v,
                              input logic j_m, input logic [31:0] jt_v,
                              input logic b, input logic [31:0] bt_v,
                              input logic [31:0] epc, input logic [1:0] est,
                              input logic emis, input logic [31:0] ecnt);
    vec_t v;
    v.name = nm; v.stall = s; v.exc = e; v.halt = h; v.resume = r;
    v.jr = j_r; v.rt = rt_v; v.jmp = j_m; v.jt = jt_v; v.br = b; v.bt = bt_v;
    v.e_pc = epc; v.e_st = est; v.e_mis = emis; v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; branch_taken = 0; jump = 0; jr = 0; exception = 0;
    halt = 0; resume = 0; branch_target = 0; jump_target = 0; reg_target = 0;
  endtask

  task automatic check_outputs(input exp_t e);
    logic [31:0] pps;
    pps = e.pc + 32'd4;
    check({e.name, " pc"}, 64'(pc), 64'(e.pc));
    check({e.name, " state"}, 64'(state), 64'(e.st));
    check({e.name, " pc_valid"}, 64'(pc_valid), 64'(e.st == 2'd1));
    check({e.name, " misaligned"}, 64'(misaligned), 64'(e.mis));
    check({e.name, " fetch_count"}, 64'(fetch_count), 64'(e.cnt));
    check({e.name, " pc_plus_step"}, 64'(pc_plus_step), 64'(pps));
  endtask

  // One edge: expectation queued as stimulus is driven, popped after the edge.
  task automatic step(input exp_t e);
    exp_t got;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: got empty queue required entry");
    end else begin
      got = sb.pop_front();
      check_outputs(got);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0;
    clear_inputs();

    //              name  stl exc hlt res jr  rt          jmp jt          br  bt          e_pc        st mis cnt
    tbl.push_back(mk("boot",  0,0,0,0, 0,32'h0,       0,32'h0,       0,32'h0,   32'h0,       1,0,0));
    tbl.push_back(mk("seq1",  0,0,0,0, 0,32'h0,       0,32'h0,       0,32'h0,   32'h4,       1,0,1));
    tbl.push_back(mk("seq2",  0,0,0,0, 0,32'h0,       0,32'h0,       0,32'h0,   32'h8,       1,0,2));
    tbl.push_back(mk("seq3",  0,0,0,0, 0,32'h0,       0,32'h0,       0,32'h0,   32'hC,       1,0,3));
    tbl.push_back(mk("jmp8a", 0,0,0,0, 0,32'h0,       1,32'h8,       0,32'h0,   32'h8,       1,0,4));
    tbl.push_back(mk("prio",  0,0,0,0, 1,32'h40,      1,32'h80,      1,32'hC0,  32'h40,      1,0,5));
    tbl.push_back(mk("jmp8b", 0,0,0,0, 0,32'h0,       1,32'h8,       0,32'h0,   32'h8,       1,0,6));
    tbl.push_back(mk("excst", 1,1,0,0, 1,32'h40,      1,32'h80,      1,32'hC0,  32'h180,     1,0,6));
    tbl.push_back(mk("jmp8c", 0,0,0,0, 0,32'h0,       1,32'h8,       0,32'h0,   32'h8,       1,0,7));
    tbl.push_back(mk("misbr", 0,0,0,0, 0,32'h0,       0,32'h0,       1,32'h102, 32'h180,     1,1,8));
    tbl.push_back(mk("misclr",0,0,0,0, 0,32'h0,       0,32'h0,       0,32'h0,   32'h184,     1,0,9));
    tbl.push_back(mk("jtop",  0,0,0,0, 0,32'h0,       1,32'hFFFFFFFC,0,32'h0,   32'hFFFFFFFC,1,0,10));
    tbl.push_back(mk("wrap",  0,0,0,0, 0,32'h0,       0,32'h0,       0,32'h0,   32'h0,       1,0,11));
    tbl.push_back(mk("stall", 1,0,0,0, 0,32'h0,       1,32'h40,      0,32'h0,   32'h0,       1,0,11));
    tbl.push_back(mk("hltstl",1,0,1,0, 0,32'h0,       0,32'h0,       0,32'h0,   32'h0,       1,0,11));
    tbl.push_back(mk("j20",   0,0,0,0, 0,32'h0,       1,32'h20,      0,32'h0,   32'h20,      1,0,12));
    tbl.push_back(mk("halt",  0,0,1,1, 0,32'h0,       0,32'h0,       0,32'h0,   32'h20,      2,0,13));
    tbl.push_back(mk("hold1", 0,0,0,0, 0,32'h0,       1,32'h80,      0,32'h0,   32'h20,      2,0,13));
    tbl.push_back(mk("hold2", 1,0,1,0, 0,32'h0,       0,32'h0,       1,32'hC0,  32'h20,      2,0,13));
    tbl.push_back(mk("hold3", 0,0,0,0, 1,32'h41,      0,32'h0,       0,32'h0,   32'h20,      2,0,13));
    tbl.push_back(mk("resume",0,0,1,1, 0,32'h0,       0,32'h0,       0,32'h0,   32'h24,      1,0,13));
    tbl.push_back(mk("halt2", 0,0,1,0, 0,32'h0,       0,32'h0,       0,32'h0,   32'h24,      2,0,14));
    tbl.push_back(mk("hexc",  0,1,0,1, 0,32'h0,       0,32'h0,       0,32'h0,   32'h180,     1,0,14));
    tbl.push_back(mk("misjr", 0,0,0,0, 1,32'h41,      1,32'h80,      0,32'h0,   32'h180,     1,1,15));
    tbl.push_back(mk("stl2",  1,0,0,0, 0,32'h0,       0,32'h0,       0,32'h0,   32'h180,     1,0,15));
    tbl.push_back(mk("j24",   0,0,0,0, 0,32'h0,       1,32'h24,      0,32'h0,   32'h24,      1,0,16));
    tbl.push_back(mk("halt3", 0,0,1,0, 0,32'h0,       0,32'h0,       0,32'h0,   32'h24,      2,0,17));

    @(negedge clk);
    e.name = "reset"; e.pc = 32'h0; e.st = 2'd0; e.mis = 1'b0; e.cnt = 32'h0;
    check_outputs(e);

    rst_n = 1'b1;
    foreach (tbl[i]) begin
      stall = tbl[i].stall; exception = tbl[i].exc; halt = tbl[i].halt;
      resume = tbl[i].resume; jr = tbl[i].jr; reg_target = tbl[i].rt;
      jump = tbl[i].jmp; jump_target = tbl[i].jt;
      branch_taken = tbl[i].br; branch_target = tbl[i].bt;
      e.name = tbl[i].name; e.pc = tbl[i].e_pc; e.st = tbl[i].e_st;
      e.mis = tbl[i].e_mis; e.cnt = tbl[i].e_cnt;
      step(e);
      @(negedge clk);
    end

    // Asynchronous reset while halted, mid-cycle, then held across edges.
    clear_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    e.name = "async_rst"; e.pc = 32'h0; e.st = 2'd0; e.mis = 1'b0; e.cnt = 32'h0;
    check_outputs(e);
    halt = 1'b1; stall = 1'b1; exception = 1'b1;
    e.name = "rst_hold";
    step(e);
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    e.name = "rel_boot"; e.pc = 32'h0; e.st = 2'd1; e.cnt = 32'h0;
    step(e);
    @(negedge clk);
    e.name = "rel_seq"; e.pc = 32'h4; e.st = 2'd1; e.cnt = 32'h1;
    step(e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
